// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the two-port memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    GRANT_IF,
    GRANT_D
  } grant_t;

  // Round-robin tie-break: the port that did not win last time goes next.
  function automatic grant_t rr_pick(input grant_t last);
    return (last == GRANT_IF) ? GRANT_D : GRANT_IF;
  endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// rtl/ctrl_bus_if.sv - clock and synchronous active-high reset bundle
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (
    input clk,
    input reset
  );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter
  import mem_arb_pkg::*;
#(
  parameter int N = 16
) (
  ctrl_bus_if.central    ctrl_bus,
  input  logic           inc,
  output logic [N-1:0]   count
);

  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + N'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  ctrl_bus_if.central         ctrl_bus,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall,
  output logic [CNT_W-1:0]    conflict_cnt
);

  arb_state_t          state, state_nx;
  grant_t              last_grant;
  logic                if_elig, d_elig;
  logic                grant_if, grant_d;
  logic                conflict;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // A port whose ready is high this cycle is still holding the old request.
  assign if_elig  = if_req & ~if_ready;
  assign d_elig   = d_req & ~d_ready;
  assign conflict = (state == IDLE) & if_elig & d_elig;

  always_comb begin
    state_nx = state;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && d_elig) begin
          if (rr_pick(last_grant) == GRANT_D) grant_d = 1'b1;
          else                                grant_if = 1'b1;
        end else if (if_elig) begin
          grant_if = 1'b1;
        end else if (d_elig) begin
          grant_d = 1'b1;
        end
        if (grant_if)     state_nx = BUSY_IF;
        else if (grant_d) state_nx = BUSY_D;
      end
      BUSY_IF: if (mem_ack) state_nx = IDLE;
      BUSY_D:  if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      state      <= IDLE;
      last_grant <= GRANT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      state    <= state_nx;
      if_ready <= (state == BUSY_IF) && mem_ack;
      d_ready  <= (state == BUSY_D) && mem_ack;
      if ((state == BUSY_IF) && mem_ack) begin
        if_rdata <= mem_rdata;
      end
      // Stores leave the last load value visible on d_rdata.
      if ((state == BUSY_D) && mem_ack && !we_q) begin
        d_rdata <= mem_rdata;
      end
      if (grant_if) begin
        addr_q     <= if_addr;
        we_q       <= 1'b0;
        last_grant <= GRANT_IF;
      end
      if (grant_d) begin
        addr_q     <= d_addr;
        we_q       <= d_we;
        wdata_q    <= d_wdata;
        last_grant <= GRANT_D;
      end
    end
  end

  assign mem_req   = (state != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall     = (if_req & ~if_ready) | (d_req & ~d_ready);

  sat_counter #(
    .N (CNT_W)
  ) u_conflict_cnt (
    .ctrl_bus (ctrl_bus),
    .inc      (conflict),
    .count    (conflict_cnt)
  );

endmodule
